maxpool2x2_mc: RTL

- Parametrised 2x2/stride-2 pooling engine between a conv layer's row-pair mid BRAMs and the next layer's row BRAMs.
- Generalises the fixed 3-channel max pool to CH channels, configurable input/output widths and map size.
- Adds runtime max/average mode, optional ReLU, signed saturation IBD->BD, and round-robin distribution of output rows over NB destination BRAMs.

---
 rtl/maxpool2x2_mc_if.sv | 30 +++
 rtl/maxpool2x2_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_mc_if.sv
// Bus bundle between the pooling engine, its source mid BRAMs (read side)
// and the destination row BRAMs (write side).
interface maxpool2x2_mc_if #(
  parameter int IBD = 21,
  parameter int BD  = 18,
  parameter int CH  = 3,
  parameter int AW  = 11,
  parameter int BNW = 2
);
  logic [CH*IBD-1:0] q0;
  logic [CH*IBD-1:0] q1;
  logic              mpen;
  logic [AW-1:0]     rdaddr;
  logic              wren;
  logic [AW-1:0]     wraddr;
  logic [CH*BD-1:0]  d;
  logic [BNW-1:0]    bram_num;

  // The pooling engine drives addresses and write data.
  modport master (
    input  q0, q1,
    output mpen, rdaddr, wren, wraddr, d, bram_num
  );

  // The memory side returns read data and absorbs writes.
  modport slave (
    output q0, q1,
    input  mpen, rdaddr, wren, wraddr, d, bram_num
  );
endinterface

// File: rtl/maxpool2x2_mc.sv
// 2x2 / stride-2 max or average pooling over CH channels with optional ReLU,
// signed saturation IBD->BD and round-robin output rows across NB BRAMs.
module maxpool2x2_mc #(
  parameter int IBD  = 21,
  parameter int BD   = 18,
  parameter int CH   = 3,
  parameter int IN_W = 32,
  parameter int IN_H = 32,
  parameter int NB   = 4,
  parameter int AW   = 11,
  localparam int BNW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ready_in,
  input  logic            mode,
  input  logic            relu_en,
  output logic            busy,
  output logic            next_st,
  maxpool2x2_mc_if.master bus
);

  localparam int SW = IBD + 2;
  localparam logic [AW-1:0]        LAST_RD   = AW'((IN_H / 2) * IN_W - 1);
  localparam logic [AW-1:0]        HALF_W_A  = AW'(IN_W / 2);
  localparam logic [AW-1:0]        LAST_CP   = AW'(IN_W / 2 - 1);
  localparam logic [BNW-1:0]       LAST_BANK = BNW'(NB - 1);
  localparam logic signed [SW-1:0] SAT_MAX   = SW'(2 ** (BD - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN   = SW'(-(2 ** (BD - 1)));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          drain_q, drain_d;
  logic          mpen_q, mpen_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic          busy_q, busy_d;
  logic          next_st_q, next_st_d;
  logic          mode_q, mode_d;
  logic          relu_q, relu_d;
  logic          start;

  // Read-return tracking: data on q0/q1 this cycle and its column parity.
  logic          v1_q;
  logic          odd1_q;
  logic          wr_fire;

  logic              wren_q;
  logic [AW-1:0]     wraddr_q;
  logic [CH*BD-1:0]  d_q;
  logic [CH*BD-1:0]  d_next;
  logic [BNW-1:0]    bram_num_q;
  logic [AW-1:0]     cp_q;
  logic [BNW-1:0]    bank_q;
  logic [AW-1:0]     wbase_q;

  always_comb begin
    // NOTE: every next-state signal takes a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    drain_d   = drain_q;
    mpen_d    = mpen_q;
    rdaddr_d  = rdaddr_q;
    busy_d    = busy_q;
    next_st_d = 1'b0;
    mode_d    = mode_q;
    relu_d    = relu_q;
    start     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready_in) begin
          state_d  = S_READ;
          mpen_d   = 1'b1;
          rdaddr_d = '0;
          busy_d   = 1'b1;
          mode_d   = mode;
          relu_d   = relu_en;
          start    = 1'b1;
        end
      end
      S_READ: begin
        if (rdaddr_q == LAST_RD) begin
          state_d = S_DRAIN;
          mpen_d  = 1'b0;
          drain_d = 1'b0;
        end else begin
          rdaddr_d = rdaddr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Two cycles: read return, then the final write register stage.
        if (drain_q) begin
          state_d   = S_DONE;
          next_st_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: flops use non-blocking assignments only, so every register samples
    // pre-edge values no matter how the always blocks are ordered.
    if (!reset) begin
      state_q   <= S_IDLE;
      drain_q   <= 1'b0;
      mpen_q    <= 1'b0;
      rdaddr_q  <= '0;
      busy_q    <= 1'b0;
      next_st_q <= 1'b0;
      mode_q    <= 1'b0;
      relu_q    <= 1'b0;
      v1_q      <= 1'b0;
      odd1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      mpen_q    <= mpen_d;
      rdaddr_q  <= rdaddr_d;
      busy_q    <= busy_d;
      next_st_q <= next_st_d;
      mode_q    <= mode_d;
      relu_q    <= relu_d;
      v1_q      <= mpen_q;
      odd1_q    <= rdaddr_q[0];
    end
  end

  // IN_W is even, so address parity equals column parity.
  assign wr_fire = v1_q & odd1_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [SW-1:0] a, b, pair, sum4, comb4, fin;
    logic signed [BD-1:0] sat;
    logic signed [SW-1:0] hold_q;

    assign a     = SW'($signed(bus.q0[k*IBD +: IBD]));
    assign b     = SW'($signed(bus.q1[k*IBD +: IBD]));
    assign pair  = mode_q ? (a + b) : ((a > b) ? a : b);
    assign sum4  = hold_q + pair;
    assign comb4 = mode_q ? (sum4 >>> 2) : ((hold_q > pair) ? hold_q : pair);
    assign fin   = (relu_q && comb4[SW-1]) ? '0 : comb4;
    assign sat   = (fin > SAT_MAX) ? SAT_MAX[BD-1:0] :
                   (fin < SAT_MIN) ? SAT_MIN[BD-1:0] : fin[BD-1:0];
    assign d_next[k*BD +: BD] = sat;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
      end else if (v1_q && !odd1_q) begin
        hold_q <= pair;
      end
    end
  end

  // Output write stage and row/column/bank bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      d_q        <= '0;
      bram_num_q <= '0;
      cp_q       <= '0;
      bank_q     <= '0;
      wbase_q    <= '0;
    end else begin
      wren_q <= wr_fire;
      if (start) begin
        cp_q    <= '0;
        bank_q  <= '0;
        wbase_q <= '0;
      end else if (wr_fire) begin
        d_q        <= d_next;
        wraddr_q   <= wbase_q + cp_q;
        bram_num_q <= bank_q;
        if (cp_q == LAST_CP) begin
          cp_q <= '0;
          if (bank_q == LAST_BANK) begin
            bank_q  <= '0;
            wbase_q <= wbase_q + HALF_W_A;
          end else begin
            bank_q <= bank_q + 1'b1;
          end
        end else begin
          cp_q <= cp_q + 1'b1;
        end
      end
    end
  end

  assign bus.mpen     = mpen_q;
  assign bus.rdaddr   = rdaddr_q;
  assign bus.wren     = wren_q;
  assign bus.wraddr   = wraddr_q;
  assign bus.d        = d_q;
  assign bus.bram_num = bram_num_q;
  assign busy         = busy_q;
  assign next_st      = next_st_q;

endmodule
